shr_frame_loader: RTL and testbench



---
 rtl/shr_frame_loader.sv | 185 ++++++++++++++++++
 tb/tb_shr_frame_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shr_frame_loader.sv
// rtl/shr_frame_loader.sv - multi-channel parallel-to-serial shift-register frame loader
module shr_frame_loader #(
    parameter int DATA_W    = 16,
    parameter int N_CH      = 2,
    parameter int CLK_DIV   = 4,
    parameter int SYN_W     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     trig,
    input  logic                     dump,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic                     sclk,
    output logic [N_CH-1:0]          din,
    output logic                     syn,
    output logic                     out_en,
    output logic                     clk_out_en,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_MAX = (DATA_W > SYN_W) ? DATA_W : SYN_W;
    localparam int BIT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] SYN_LAST  = BIT_W'(SYN_W - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Sequencer state
    state_t                         state_q, state_d;
    logic [DIV_W-1:0]               div_q, div_d;
    logic                           phase_q, phase_d;   // 0 = sclk low half, 1 = sclk high half
    logic [BIT_W-1:0]               bit_q, bit_d;
    logic [N_CH-1:0][DATA_W-1:0]    sh_q, sh_d;
    logic                           trig_prev_q, trig_prev_d;

    // Registered outputs
    logic                           sclk_q, sclk_d;
    logic [N_CH-1:0]                din_q, din_d;
    logic                           syn_q, syn_d;
    logic                           out_en_q, out_en_d;
    logic                           clk_out_en_q, clk_out_en_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           tick;

    assign tick = (div_q == DIV_LAST);

    // Next-state: timebase, bit-period sequencing, capture and shifting
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        trig_prev_d = trig;

        if (state_q == ST_IDLE) begin
            if (trig && !trig_prev_q) begin
                state_d = ST_SYNC;
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                sh_d    = data;
            end
        end else if (!tick) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                // End of a full bit period (H -> L transition)
                phase_d = 1'b0;
                bit_d   = bit_q + 1'b1;
                case (state_q)
                    ST_SYNC: begin
                        if (bit_q == SYN_LAST) begin
                            state_d = ST_SHIFT;
                            bit_d   = '0;
                        end
                    end
                    ST_SHIFT: begin
                        for (int c = 0; c < N_CH; c++) begin
                            if (MSB_FIRST != 0) begin
                                sh_d[c] = {sh_q[c][DATA_W-2:0], 1'b0};
                            end else begin
                                sh_d[c] = {1'b0, sh_q[c][DATA_W-1:1]};
                            end
                        end
                        if (bit_q == DATA_LAST) begin
                            state_d = ST_GAP;
                            bit_d   = '0;
                        end
                    end
                    ST_GAP: begin
                        bit_d = '0;
                        if (dump) begin
                            // Back-to-back repeat: fresh data, no idle cycle
                            state_d = ST_SYNC;
                            sh_d    = data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        sclk_d       = (state_d == ST_SHIFT) && phase_d;
        syn_d        = (state_d == ST_SYNC);
        out_en_d     = (state_d != ST_IDLE);
        clk_out_en_d = (state_d == ST_SHIFT);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_GAP) && phase_d && (div_d == DIV_LAST);
        din_d        = '0;
        if (state_d == ST_SHIFT) begin
            for (int c = 0; c < N_CH; c++) begin
                if (MSB_FIRST != 0) begin
                    din_d[c] = sh_d[c][DATA_W-1];
                end else begin
                    din_d[c] = sh_d[c][0];
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            phase_q      <= 1'b0;
            bit_q        <= '0;
            sh_q         <= '0;
            trig_prev_q  <= 1'b0;
            sclk_q       <= 1'b0;
            din_q        <= '0;
            syn_q        <= 1'b0;
            out_en_q     <= 1'b0;
            clk_out_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            trig_prev_q  <= trig_prev_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            syn_q        <= syn_d;
            out_en_q     <= out_en_d;
            clk_out_en_q <= clk_out_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sclk       = sclk_q;
    assign din        = din_q;
    assign syn        = syn_q;
    assign out_en     = out_en_q;
    assign clk_out_en = clk_out_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shr_frame_loader.sv
// tb/tb_shr_frame_loader.sv - scoreboard bench for shr_frame_loader
module tb_shr_frame_loader;

    logic        clk;
    logic        rst;
    logic        trig_a, dump_a, trig_b, dump_b;
    logic [31:0] data_a;
    logic [4:0]  data_b;

    logic        sclk_a, syn_a, out_en_a, clk_out_en_a, busy_a, done_a;
    logic [1:0]  din_a;
    logic        sclk_b, syn_b, out_en_b, clk_out_en_b, busy_b, done_b;
    logic [0:0]  din_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;

    typedef struct {
        int         cyc;
        logic [1:0] bits;
    } rise_t;

    rise_t qa_rise[$];
    rise_t qb_rise[$];
    int    qa_done[$];
    int    qb_done[$];

    shr_frame_loader u_a (
        .clk_in(clk), .rst(rst), .trig(trig_a), .dump(dump_a), .data(data_a),
        .sclk(sclk_a), .din(din_a), .syn(syn_a), .out_en(out_en_a),
        .clk_out_en(clk_out_en_a), .busy(busy_a), .done(done_a)
    );

    shr_frame_loader #(
        .DATA_W(5), .N_CH(1), .CLK_DIV(1), .SYN_W(2), .MSB_FIRST(0)
    ) u_b (
        .clk_in(clk), .rst(rst), .trig(trig_b), .dump(dump_b), .data(data_b),
        .sclk(sclk_b), .din(din_b), .syn(syn_b), .out_en(out_en_b),
        .clk_out_en(clk_out_en_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int rel);
        while (cyc < base + rel) wait_cycle();
    endtask

    // Expected default-config frame: rises at b+13+8i, MSB first, done at b+144
    task automatic push_a(input int b, input logic [15:0] w0, input logic [15:0] w1,
                          input int nbits, input bit with_done);
        rise_t r;
        for (int i = 0; i < nbits; i++) begin
            r.cyc  = b + 13 + 8 * i;
            r.bits = {w1[15-i], w0[15-i]};
            qa_rise.push_back(r);
        end
        if (with_done) qa_done.push_back(b + 144);
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, "_sclk"}, sclk_a, 0);
        check({tag, "_din"}, din_a, 0);
        check({tag, "_syn"}, syn_a, 0);
        check({tag, "_out_en"}, out_en_a, 0);
        check({tag, "_clk_out_en"}, clk_out_en_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
    endtask

    // Monitor: compare each sclk rise and done pulse against the scoreboard
    initial begin
        rise_t r;
        logic  pa, pb;
        pa = 1'b0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sclk_a && !pa) begin
                    if (qa_rise.size() == 0) unexpected("a_rise");
                    else begin
                        r = qa_rise.pop_front();
                        check("a_rise_cycle", cyc, r.cyc);
                        check("a_din", din_a, r.bits);
                    end
                end
                if (done_a) begin
                    if (qa_done.size() == 0) unexpected("a_done");
                    else check("a_done_cycle", cyc, qa_done.pop_front());
                end
                if (sclk_b && !pb) begin
                    if (qb_rise.size() == 0) unexpected("b_rise");
                    else begin
                        r = qb_rise.pop_front();
                        check("b_rise_cycle", cyc, r.cyc);
                        check("b_din", din_b, r.bits[0]);
                    end
                end
                if (done_b) begin
                    if (qb_done.size() == 0) unexpected("b_done");
                    else check("b_done_cycle", cyc, qb_done.pop_front());
                end
            end
            pa = sclk_a;
            pb = sclk_b;
        end
    end

    // Stimulus
    initial begin
        rise_t       r;
        logic [4:0]  wb;
        rst    = 1'b1;
        trig_a = 1'b0;
        trig_b = 1'b0;
        dump_a = 1'b0;
        dump_b = 1'b0;
        data_a = 32'h0;
        data_b = 5'b0;
        repeat (3) wait_cycle();
        check_a_idle("reset");
        check("reset_b_busy", busy_b, 0);
        rst = 1'b0;
        repeat (3) wait_cycle();

        // Single frame, default parameters
        data_a = {16'h0001, 16'hA5C3};
        base = cyc;
        push_a(base, 16'b1010_0101_1100_0011, 16'h0001, 16, 1'b1);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        check("t1_syn_c1", syn_a, 1);
        check("t1_busy_c1", busy_a, 1);
        check("t1_out_en_c1", out_en_a, 1);
        check("t1_sclk_c1", sclk_a, 0);
        goto(8);   check("t1_syn_c8", syn_a, 1);
        goto(9);   check("t1_syn_c9", syn_a, 0);
                   check("t1_clk_out_en_c9", clk_out_en_a, 1);
        goto(13);  check("t1_sclk_c13", sclk_a, 1);
        goto(137); check("t1_gap_out_en", out_en_a, 1);
                   check("t1_gap_sclk", sclk_a, 0);
        goto(144); check("t1_done_c144", done_a, 1);
                   check("t1_busy_c144", busy_a, 1);
        goto(145); check("t1_busy_c145", busy_a, 0);
                   check("t1_done_c145", done_a, 0);
        goto(160);

        // Dump mode, data changed mid-frame 1, three frames
        dump_a = 1'b1;
        base = cyc;
        push_a(base, 16'hA5C3, 16'h0001, 16, 1'b1);
        push_a(base + 144, 16'h3C5A, 16'h8001, 16, 1'b1);
        push_a(base + 288, 16'h3C5A, 16'h8001, 16, 1'b1);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(50);  data_a = {16'h8001, 16'h3C5A};
        goto(145); check("t2_busy_f2", busy_a, 1);
                   check("t2_syn_f2", syn_a, 1);
        goto(289); check("t2_busy_f3", busy_a, 1);
                   check("t2_syn_f3", syn_a, 1);
        goto(300); dump_a = 1'b0;
        goto(433); check("t2_busy_end", busy_a, 0);
        goto(450);

        // Re-pulsed trig while busy, then trig held high
        data_a = {16'h0001, 16'hA5C3};
        base = cyc;
        push_a(base, 16'hA5C3, 16'h0001, 16, 1'b1);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(50);  trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(145); check("t3_busy_145", busy_a, 0);
        goto(200); check("t3_busy_200", busy_a, 0);
        base = cyc;
        push_a(base, 16'hA5C3, 16'h0001, 16, 1'b1);
        trig_a = 1'b1;
        goto(300); check("t3_held_busy", busy_a, 0);
        trig_a = 1'b0;
        goto(320); check("t3_held_busy2", busy_a, 0);

        // Reset during SHIFT bit 7
        base = cyc;
        push_a(base, 16'hA5C3, 16'h0001, 7, 1'b0);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(66);  check("t4_in_shift", clk_out_en_a, 1);
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        check_a_idle("t4_after_rst");
        goto(80);  check("t4_idle", busy_a, 0);
        base = cyc;
        push_a(base, 16'hA5C3, 16'h0001, 16, 1'b1);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(160); check("t4_reframe_end", busy_a, 0);

        // Small configuration, LSB first
        data_b = 5'b10110;
        wb = 5'b10110;
        base = cyc;
        for (int i = 0; i < 5; i++) begin
            r.cyc  = base + 6 + 2 * i;
            r.bits = {1'b0, wb[i]};
            qb_rise.push_back(r);
        end
        qb_done.push_back(base + 16);
        trig_b = 1'b1;
        wait_cycle();
        trig_b = 1'b0;
        check("t5_syn_c1", syn_b, 1);
        goto(5);   check("t5_syn_c5", syn_b, 0);
        goto(16);  check("t5_done_c16", done_b, 1);
        goto(17);  check("t5_busy_c17", busy_b, 0);
        goto(30);

        // Dump dropped mid-frame 2
        data_a = {16'h1234, 16'hFEDC};
        dump_a = 1'b1;
        base = cyc;
        push_a(base, 16'hFEDC, 16'h1234, 16, 1'b1);
        push_a(base + 144, 16'hFEDC, 16'h1234, 16, 1'b1);
        trig_a = 1'b1;
        wait_cycle();
        trig_a = 1'b0;
        goto(204); dump_a = 1'b0;
        goto(288); check("t6_busy_288", busy_a, 1);
        goto(289); check("t6_busy_289", busy_a, 0);
        goto(340); check("t6_no_frame3", busy_a, 0);

        check("qa_rise_empty", qa_rise.size(), 0);
        check("qa_done_empty", qa_done.size(), 0);
        check("qb_rise_empty", qb_rise.size(), 0);
        check("qb_done_empty", qb_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
